// File: rtl/slave_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : slave_port_if
//  Description : Serial system-bus link between a master port and a slave
//                port. The master drives the frame strobe, the mode and the
//                serial address/write-data lines. The slave drives the
//                ready flag and the serial read-data return.
//  Signals     : sp_valid, sp_mode, sp_addr, sp_wdata  master -> slave
//                sp_ready, sp_rdata, sp_rvalid         slave  -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface slave_port_if;
  logic sp_valid;
  logic sp_mode;
  logic sp_addr;
  logic sp_wdata;
  logic sp_ready;
  logic sp_rdata;
  logic sp_rvalid;

  modport master (
    output sp_valid, sp_mode, sp_addr, sp_wdata,
    input  sp_ready, sp_rdata, sp_rvalid
  );

  modport slave (
    input  sp_valid, sp_mode, sp_addr, sp_wdata,
    output sp_ready, sp_rdata, sp_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : slave_port
//  Description : Bus-side responder for the serial system bus. Deserialises
//                a slave-local address (and write data) from one-bit lines,
//                issues one parallel access to the attached slave and, for
//                reads, returns the slave data serially, LSB first.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                sp              serial bus (slave modport of slave_port_if)
//                s_addr/s_wdata  parallel address / write data to slave
//                s_wen/s_valid   access type / request to slave
//                s_ready/s_rdata slave acceptance / read data
//  Revision    : 1.0  initial release
// ============================================================================
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_port_if.slave           sp,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_wen,
  output logic                  s_valid,
  input  logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_rdata
);

  // Counter spans both the frame bit index and the read-return beat count.
  localparam int                CNT_W         = $clog2(ADDR_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_BITS     = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    REQ  = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    mode_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rsh_q;
  logic                    sp_ready_q;
  logic                    sp_rdata_q;
  logic                    sp_rvalid_q;
  logic                    s_valid_q;
  logic                    s_wen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsh_q       <= '0;
      sp_ready_q  <= 1'b1;
      sp_rdata_q  <= 1'b0;
      sp_rvalid_q <= 1'b0;
      s_valid_q   <= 1'b0;
      s_wen_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sp.sp_valid) begin
            // Bits arrive LSB first: shifting in from the top leaves bit 0
            // in position 0 once the whole field has been received.
            mode_q     <= sp.sp_mode;
            addr_q     <= {sp.sp_addr, addr_q[ADDR_WIDTH-1:1]};
            if (sp.sp_mode) begin
              wdata_q <= {sp.sp_wdata, wdata_q[DATA_WIDTH-1:1]};
            end
            cnt_q      <= CNT_ONE;
            sp_ready_q <= 1'b0;
            state_q    <= RX;
          end
        end

        RX: begin
          if (!sp.sp_valid) begin
            // Truncated frame: drop it without touching the slave.
            cnt_q      <= '0;
            sp_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            addr_q <= {sp.sp_addr, addr_q[ADDR_WIDTH-1:1]};
            if (mode_q && (cnt_q < DATA_BITS)) begin
              wdata_q <= {sp.sp_wdata, wdata_q[DATA_WIDTH-1:1]};
            end
            if (cnt_q == LAST_ADDR_BIT) begin
              cnt_q     <= '0;
              s_valid_q <= 1'b1;
              s_wen_q   <= mode_q;
              state_q   <= REQ;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        REQ: begin
          if (s_ready) begin
            s_valid_q <= 1'b0;
            s_wen_q   <= 1'b0;
            if (mode_q) begin
              sp_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              // Bit 0 goes straight out; the rest waits in the shifter.
              sp_rdata_q  <= s_rdata[0];
              rsh_q       <= s_rdata >> 1;
              sp_rvalid_q <= 1'b1;
              cnt_q       <= CNT_ONE;
              state_q     <= RSP;
            end
          end
        end

        RSP: begin
          if (cnt_q == DATA_BITS) begin
            sp_rvalid_q <= 1'b0;
            sp_rdata_q  <= 1'b0;
            sp_ready_q  <= 1'b1;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else begin
            sp_rdata_q <= rsh_q[0];
            rsh_q      <= rsh_q >> 1;
            cnt_q      <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sp.sp_ready  = sp_ready_q;
  assign sp.sp_rdata  = sp_rdata_q;
  assign sp.sp_rvalid = sp_rvalid_q;
  assign s_addr       = addr_q;
  assign s_wdata      = wdata_q;
  assign s_wen        = s_wen_q;
  assign s_valid      = s_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_port
//  Description : Directed self-checking bench for slave_port. Drives serial
//                frames through slave_port_if and checks the parallel slave
//                access and the serial read return against hand-computed
//                values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_wen;
  logic          s_valid;
  logic          s_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int sv_cnt   = 0;

  logic [AW-1:0] hs_addr[$];
  logic          hs_wen[$];
  logic [DW-1:0] hs_wd[$];

  always #5 clk = ~clk;

  slave_port_if bus();

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .sp      (bus),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wen   (s_wen),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_rdata (s_rdata)
  );

  // Slave-side observer: every cycle of s_valid, and every handshake.
  always @(negedge clk) begin
    if (s_valid) sv_cnt++;
    if (s_valid && s_ready) begin
      hs_addr.push_back(s_addr);
      hs_wen.push_back(s_wen);
      hs_wd.push_back(s_wdata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one full frame; returns one step into cycle T+ADDR_WIDTH.
  // Mode is inverted after cycle 0 and wdata is forced high after the data
  // field so that both must be ignored by the DUT.
  task automatic send_frame(input logic mode, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < AW; i++) begin
      bus.sp_valid = 1'b1;
      bus.sp_mode  = (i == 0) ? mode : ~mode;
      bus.sp_addr  = a[i];
      bus.sp_wdata = (i < DW) ? d[i] : 1'b1;
      tick();
    end
    bus.sp_valid = 1'b0;
    bus.sp_mode  = 1'b0;
    bus.sp_addr  = 1'b0;
    bus.sp_wdata = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    @(negedge clk);
    check_val({tag, ".s_valid"}, s_valid, 1);
    check_val({tag, ".s_addr"}, s_addr, a);
    check_val({tag, ".s_wen"}, s_wen, w);
    if (w) check_val({tag, ".s_wdata"}, s_wdata, d);
    check_val({tag, ".sp_ready"}, bus.sp_ready, 0);
  endtask

  task automatic check_read(input string tag, input logic [DW-1:0] exp);
    for (int k = 0; k < DW; k++) begin
      @(negedge clk);
      check_val({tag, ".rvalid"}, bus.sp_rvalid, 1);
      check_val({tag, ".rdata"}, bus.sp_rdata, exp[k]);
      check_val({tag, ".ready_busy"}, bus.sp_ready, 0);
      tick();
    end
    @(negedge clk);
    check_val({tag, ".rvalid_end"}, bus.sp_rvalid, 0);
    check_val({tag, ".rdata_end"}, bus.sp_rdata, 0);
    check_val({tag, ".ready_end"}, bus.sp_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int sv0;
    int hs0;
    logic [DW-1:0] rd;

    rst          = 1'b1;
    bus.sp_valid = 1'b0;
    bus.sp_mode  = 1'b0;
    bus.sp_addr  = 1'b0;
    bus.sp_wdata = 1'b0;
    s_ready      = 1'b1;
    s_rdata      = '0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check_val("rst.sp_ready", bus.sp_ready, 1);
    check_val("rst.sp_rvalid", bus.sp_rvalid, 0);
    check_val("rst.sp_rdata", bus.sp_rdata, 0);
    check_val("rst.s_valid", s_valid, 0);
    check_val("rst.s_wen", s_wen, 0);
    check_val("rst.s_addr", s_addr, 0);
    check_val("rst.s_wdata", s_wdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: write 0x234 / 0xA5
    sv0 = sv_cnt;
    send_frame(1'b1, 12'h234, 8'hA5);
    check_req("wr1", 12'h234, 8'hA5, 1'b1);
    tick();
    @(negedge clk);
    check_val("wr1.s_valid_drop", s_valid, 0);
    check_val("wr1.sp_ready", bus.sp_ready, 1);
    check_val("wr1.sp_rvalid", bus.sp_rvalid, 0);
    check_val("wr1.valid_cycles", sv_cnt - sv0, 1);
    tick();

    // 2: read 0x0F0 returning 0x3C
    s_rdata = 8'h3C;
    send_frame(1'b0, 12'h0F0, 8'h00);
    check_req("rd2", 12'h0F0, 8'h00, 1'b0);
    tick();
    check_read("rd2", 8'h3C);
    tick();

    // 3: backpressure, s_ready low for 3 cycles
    s_ready = 1'b0;
    sv0 = sv_cnt;
    hs0 = hs_addr.size();
    send_frame(1'b1, 12'h7FF, 8'h01);
    for (int j = 0; j < 4; j++) begin
      check_req("bp3", 12'h7FF, 8'h01, 1'b1);
      tick();
      if (j == 2) s_ready = 1'b1;
    end
    @(negedge clk);
    check_val("bp3.s_valid_drop", s_valid, 0);
    check_val("bp3.sp_ready", bus.sp_ready, 1);
    check_val("bp3.valid_cycles", sv_cnt - sv0, 4);
    check_val("bp3.handshakes", hs_addr.size() - hs0, 1);
    tick();

    // 4: abort after 5 address bits, then a full write
    sv0 = sv_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.sp_valid = 1'b1;
      bus.sp_mode  = 1'b1;
      bus.sp_addr  = (i % 2 == 0);
      bus.sp_wdata = 1'b1;
      tick();
    end
    bus.sp_valid = 1'b0;
    tick();
    @(negedge clk);
    check_val("ab4.sp_ready", bus.sp_ready, 1);
    repeat (15) tick();
    check_val("ab4.no_access", sv_cnt - sv0, 0);
    send_frame(1'b1, 12'h001, 8'h55);
    check_req("ab4.wr", 12'h001, 8'h55, 1'b1);
    tick();
    @(negedge clk);
    check_val("ab4.ready_after", bus.sp_ready, 1);
    tick();

    // 5: reset on the third read-return cycle
    rd = 8'h96;
    s_rdata = rd;
    send_frame(1'b0, 12'h155, 8'h00);
    check_req("rs5", 12'h155, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("rs5.rdata", bus.sp_rdata, rd[k]);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check_val("rs5.rvalid3", bus.sp_rvalid, 1);
    check_val("rs5.rdata3", bus.sp_rdata, rd[2]);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("rs5.rvalid_rst", bus.sp_rvalid, 0);
    check_val("rs5.rdata_rst", bus.sp_rdata, 0);
    check_val("rs5.ready_rst", bus.sp_ready, 1);
    check_val("rs5.s_valid_rst", s_valid, 0);
    tick();
    s_rdata = 8'h5A;
    send_frame(1'b0, 12'h0AA, 8'h00);
    check_req("rs5.rd", 12'h0AA, 8'h00, 1'b0);
    tick();
    check_read("rs5.rd", 8'h5A);
    tick();

    // 6: back-to-back write then read
    hs0 = hs_addr.size();
    send_frame(1'b1, 12'h123, 8'hC3);
    check_req("bb6.wr", 12'h123, 8'hC3, 1'b1);
    tick();
    @(negedge clk);
    check_val("bb6.ready", bus.sp_ready, 1);
    s_rdata = 8'hE1;
    send_frame(1'b0, 12'h456, 8'h00);
    check_req("bb6.rd", 12'h456, 8'h00, 1'b0);
    tick();
    check_read("bb6.rd", 8'hE1);
    check_val("bb6.handshakes", hs_addr.size() - hs0, 2);
    if (hs_addr.size() - hs0 == 2) begin
      check_val("bb6.hs0_addr", hs_addr[hs0], 12'h123);
      check_val("bb6.hs0_wen", hs_wen[hs0], 1);
      check_val("bb6.hs0_wdata", hs_wd[hs0], 8'hC3);
      check_val("bb6.hs1_addr", hs_addr[hs0+1], 12'h456);
      check_val("bb6.hs1_wen", hs_wen[hs0+1], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slave_port.md
Name: slave_port

Overview:
- Bus-side responder for the serial system bus. It is the far end of the link driven by the master port.
- Deserialises a slave-local address and write data arriving on one-bit lines, then issues one parallel access to the attached slave memory/peripheral.
- For reads, returns the data serially.
- One instance sits in front of each slave. Upper-address slave selection is done by the bus decoder, not here.

Parameters:
- ADDR_WIDTH, 12, slave-local address bits; also the frame length in cycles. Must be >= DATA_WIDTH.
- DATA_WIDTH, 8, data word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sp_valid  in  1  frame strobe from master; high for every cycle of a frame.
- sp_mode  in  1  1=write, 0=read; sampled on the first frame cycle only.
- sp_addr  in  1  serial address, LSB first.
- sp_wdata  in  1  serial write data, LSB first, on frame cycles 0..DATA_WIDTH-1.
- sp_ready  out  1  high when able to accept a new frame.
- sp_rdata  out  1  serial read data, LSB first.
- sp_rvalid  out  1  qualifies sp_rdata.
- s_addr  out  ADDR_WIDTH  parallel address to slave.
- s_wdata  out  DATA_WIDTH  parallel write data to slave.
- s_wen  out  1  1=write access.
- s_valid  out  1  access request to slave.
- s_ready  in  1  slave accepts the access; for reads, s_rdata is valid in the same cycle.
- s_rdata  in  DATA_WIDTH  read data from slave.

Behaviour:
- Reset values:
  - sp_ready=1; sp_rvalid=0; sp_rdata=0.
  - s_valid=0; s_wen=0; s_addr=0; s_wdata=0.
  - State=IDLE; bit counter=0.
- States: IDLE, RX, REQ, RSP.
- IDLE:
  - sp_ready=1.
  - When sp_valid=1: latch sp_mode, shift in bit 0 of sp_addr and sp_wdata, set counter=1, go to RX.
  - sp_valid while not in IDLE is never treated as a new frame start.
- RX:
  - sp_ready=0.
  - Each cycle with sp_valid=1: shift in address bit [counter].
  - Write data bit [counter] is shifted in only while counter < DATA_WIDTH; sp_wdata is ignored afterwards and for reads.
  - The cycle sampling bit ADDR_WIDTH-1 moves to REQ.
  - sp_valid=0 in RX: abort. Go to IDLE, discard the frame, no slave access.
- REQ:
  - s_valid=1, with s_addr, s_wdata and s_wen=mode held stable from registers.
  - Hold until s_ready=1 (unbounded wait).
  - On the handshake cycle:
    - write: go to IDLE.
    - read: capture s_rdata into the shift register, go to RSP.
  - s_valid drops the cycle after the handshake.
- RSP:
  - sp_rvalid=1 for exactly DATA_WIDTH consecutive cycles; sp_rdata = captured bit 0, 1, ... in order.
  - Then go to IDLE. sp_rvalid=0 and sp_rdata=0 outside RSP.
- Latency (frame first cycle T, s_ready held high):
  - s_valid high at T+ADDR_WIDTH.
  - Write: sp_ready high at T+ADDR_WIDTH+1.
  - Read: sp_rvalid high T+ADDR_WIDTH+1 .. T+ADDR_WIDTH+DATA_WIDTH; sp_ready high at T+ADDR_WIDTH+DATA_WIDTH+1.
- All outputs are registered. No combinational path from s_ready or sp_valid to any output.
- Back-to-back frames: a frame may start in the first cycle sp_ready=1.
- Reset mid-operation (any state): next cycle is IDLE with reset values; any pending s_valid or serial read is dropped.
- s_ready asserted outside REQ is ignored.

Test Plan:
All scenarios use ADDR_WIDTH=12, DATA_WIDTH=8.
1. Write frame: addr 0x234, data 0xA5, mode=1, s_ready=1 -> s_valid for one cycle at T+12 with s_addr=0x234, s_wdata=0xA5, s_wen=1; sp_ready back to 1 at T+13; sp_rvalid stays 0.
2. Read frame: addr 0x0F0, s_rdata=0x3C, s_ready=1 -> s_wen=0, s_addr=0x0F0; sp_rvalid high for cycles T+13..T+20 with sp_rdata = 0,0,1,1,1,1,0,0; sp_ready=1 at T+21.
3. Backpressure: write 0x7FF/0x01 with s_ready low for 3 cycles after s_valid rises -> s_valid and s_addr/s_wdata stable for 4 cycles; exactly one handshake; sp_ready stays 0 until the cycle after the handshake.
4. Abort: sp_valid drops after 5 address bits -> return to IDLE; s_valid never asserts; a following full write to 0x001/0x55 completes correctly.
5. Reset mid-read: rst pulse on the 3rd sp_rvalid cycle -> next cycle sp_rvalid=0, sp_ready=1, s_valid=0; the next read frame returns correct data.
6. Back-to-back: a read frame starts in the first cycle sp_ready=1 after a write -> both accesses are seen in order with correct addresses and data.
